// File: rtl/apx_int_multiplier_if.sv
// Operand/result bundle for apx_int_multiplier: the operand side (in_valid, a, b)
// and the result side (out_valid, c_acc, c_apx).
interface apx_int_multiplier_if #(
  parameter int WIDTH_A = 32,
  parameter int WIDTH_B = 32
);
  logic               in_valid;
  logic [WIDTH_A-1:0] a;
  logic [WIDTH_B-1:0] b;
  logic               out_valid;
  logic [31:0]        c_acc;
  logic [31:0]        c_apx;

  modport master (
    output in_valid, a, b,
    input  out_valid, c_acc, c_apx
  );

  modport slave (
    input  in_valid, a, b,
    output out_valid, c_acc, c_apx
  );
endinterface

// File: rtl/apx_int_multiplier.sv
// Pipelined unsigned multiplier giving an exact and a bit-truncation approximate product (low 32 bits).
// Macro BTM_RND_EN: defined = approximate operands round to nearest 2^NAB, undefined = truncate.
module apx_int_multiplier #(
  parameter int WIDTH_A = 32,
  parameter int WIDTH_B = 32,
  parameter int NAB     = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  apx_int_multiplier_if.slave   bus
);

  localparam int RB = (NAB > 0) ? NAB - 1 : 0;
  localparam logic [WIDTH_A-1:0] MASK_A = {WIDTH_A{1'b1}} << NAB;
  localparam logic [WIDTH_B-1:0] MASK_B = {WIDTH_B{1'b1}} << NAB;

  // stage 1: captured operands
  logic [WIDTH_A-1:0] a_q, a_d;
  logic [WIDTH_B-1:0] b_q, b_d;
  logic [WIDTH_A:0]   apx_a_q, apx_a_d;
  logic [WIDTH_B:0]   apx_b_q, apx_b_d;
  logic               v1_q, v1_d;

  // stage 2: partial products; only the low 16 bits of the high partial reach the result
  logic [31:0] pp_acc_lo_q, pp_acc_lo_d;
  logic [15:0] pp_acc_hi_q, pp_acc_hi_d;
  logic [31:0] pp_apx_lo_q, pp_apx_lo_d;
  logic [15:0] pp_apx_hi_q, pp_apx_hi_d;
  logic        v2_q, v2_d;

  // stage 3: results
  logic [31:0] c_acc_q, c_acc_d;
  logic [31:0] c_apx_q, c_apx_d;
  logic        out_valid_q, out_valid_d;

  logic        rnd_a, rnd_b;
  logic [31:0] a32, b32, ax32, bx32;

  always_comb begin
    rnd_a = 1'b0;
    rnd_b = 1'b0;
`ifdef BTM_RND_EN
    if (NAB > 0) begin
      rnd_a = bus.a[RB];
      rnd_b = bus.b[RB];
    end
`endif
    a_d     = a_q;
    b_d     = b_q;
    apx_a_d = apx_a_q;
    apx_b_d = apx_b_q;
    v1_d    = bus.in_valid;
    if (bus.in_valid) begin
      a_d     = bus.a;
      b_d     = bus.b;
      // one extra bit keeps the carry when rounding up from all-ones
      apx_a_d = {1'b0, bus.a & MASK_A} + ((WIDTH_A+1)'(rnd_a) << NAB);
      apx_b_d = {1'b0, bus.b & MASK_B} + ((WIDTH_B+1)'(rnd_b) << NAB);
    end
  end

  always_comb begin
    a32  = 32'(a_q);
    b32  = 32'(b_q);
    ax32 = 32'(apx_a_q);
    bx32 = 32'(apx_b_q);
    pp_acc_lo_d = pp_acc_lo_q;
    pp_acc_hi_d = pp_acc_hi_q;
    pp_apx_lo_d = pp_apx_lo_q;
    pp_apx_hi_d = pp_apx_hi_q;
    v2_d        = v1_q;
    if (v1_q) begin
      pp_acc_lo_d = a32 * {16'b0, b32[15:0]};
      pp_acc_hi_d = 16'(a32 * {16'b0, b32[31:16]});
      pp_apx_lo_d = ax32 * {16'b0, bx32[15:0]};
      pp_apx_hi_d = 16'(ax32 * {16'b0, bx32[31:16]});
    end
  end

  always_comb begin
    c_acc_d     = c_acc_q;
    c_apx_d     = c_apx_q;
    out_valid_d = v2_q;
    if (v2_q) begin
      c_acc_d = pp_acc_lo_q + {pp_acc_hi_q, 16'b0};
      c_apx_d = pp_apx_lo_q + {pp_apx_hi_q, 16'b0};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q         <= '0;
      b_q         <= '0;
      apx_a_q     <= '0;
      apx_b_q     <= '0;
      v1_q        <= 1'b0;
      pp_acc_lo_q <= '0;
      pp_acc_hi_q <= '0;
      pp_apx_lo_q <= '0;
      pp_apx_hi_q <= '0;
      v2_q        <= 1'b0;
      c_acc_q     <= '0;
      c_apx_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      a_q         <= a_d;
      b_q         <= b_d;
      apx_a_q     <= apx_a_d;
      apx_b_q     <= apx_b_d;
      v1_q        <= v1_d;
      pp_acc_lo_q <= pp_acc_lo_d;
      pp_acc_hi_q <= pp_acc_hi_d;
      pp_apx_lo_q <= pp_apx_lo_d;
      pp_apx_hi_q <= pp_apx_hi_d;
      v2_q        <= v2_d;
      c_acc_q     <= c_acc_d;
      c_apx_q     <= c_apx_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.c_acc     = c_acc_q;
  assign bus.c_apx     = c_apx_q;

endmodule

// File: tb/tb_apx_int_multiplier.sv
// Directed bench for apx_int_multiplier: one NAB=0 and one NAB=4 instance driven in lockstep.
module tb_apx_int_multiplier;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  apx_int_multiplier_if #(.WIDTH_A(32), .WIDTH_B(32)) bus0 ();
  apx_int_multiplier_if #(.WIDTH_A(32), .WIDTH_B(32)) bus4 ();

  apx_int_multiplier #(.WIDTH_A(32), .WIDTH_B(32), .NAB(0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  apx_int_multiplier #(.WIDTH_A(32), .WIDTH_B(32), .NAB(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // NAB=4 approximate results that differ between builds
`ifdef BTM_RND_EN
  localparam logic [31:0] E4_ALL1  = 32'h0000_0000;
  localparam logic [31:0] E4_1F10  = 32'h0000_0200;
  localparam logic [31:0] E4_FF8_1 = 32'h0000_0000;
  localparam logic [31:0] E4_FF8_G = 32'h0000_0000;
`else
  localparam logic [31:0] E4_ALL1  = 32'h0000_0100;
  localparam logic [31:0] E4_1F10  = 32'h0000_0100;
  localparam logic [31:0] E4_FF8_1 = 32'h0000_0000;
  localparam logic [31:0] E4_FF8_G = 32'hFFFF_FF00;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic v, input logic [31:0] a, input logic [31:0] b);
    bus0.in_valid = v; bus0.a = a; bus0.b = b;
    bus4.in_valid = v; bus4.a = a; bus4.b = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic ov, input logic [31:0] acc,
                           input logic [31:0] apx0, input logic [31:0] apx4);
    check({tag, ".ov0"},  32'(bus0.out_valid), 32'(ov));
    check({tag, ".ov4"},  32'(bus4.out_valid), 32'(ov));
    check({tag, ".acc0"}, bus0.c_acc, acc);
    check({tag, ".apx0"}, bus0.c_apx, apx0);
    check({tag, ".acc4"}, bus4.c_acc, acc);
    check({tag, ".apx4"}, bus4.c_apx, apx4);
  endtask

  // one pair, then check not-yet-valid after one edge and valid after two
  task automatic run_pair(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] acc, input logic [31:0] apx0, input logic [31:0] apx4);
    set_in(1'b1, a, b);
    tick();
    set_in(1'b0, 32'h0, 32'h0);
    tick();
    check({tag, ".early"}, 32'(bus0.out_valid), 32'h0);
    tick();
    check_all(tag, 1'b1, acc, apx0, apx4);
  endtask

  logic [31:0] ra [500];
  logic [31:0] rb [500];

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    set_in(1'b0, 32'h0, 32'h0);
    #2;
    check_all("reset", 1'b0, 32'h0, 32'h0, 32'h0);
    tick();
    rst = 1'b1;
    tick();

    run_pair("p3x5",   32'd3,         32'd5,         32'h0000_000F, 32'h0000_000F, 32'h0);
    run_pair("pall1",  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, E4_ALL1);
    run_pair("p1fx10", 32'h1F,        32'h10,        32'h0000_01F0, 32'h0000_01F0, E4_1F10);
    run_pair("pff8x1", 32'hFFFF_FFF8, 32'h1,         32'hFFFF_FFF8, 32'hFFFF_FFF8, E4_FF8_1);
    run_pair("pff8xg", 32'hFFFF_FFF8, 32'h10,        32'hFFFF_FF80, 32'hFFFF_FF80, E4_FF8_G);

    // back-to-back stream
    set_in(1'b1, 32'd2, 32'd3);
    tick();
    set_in(1'b1, 32'd4, 32'd5);
    tick();
    check("s.early", 32'(bus0.out_valid), 32'h0);
    set_in(1'b1, 32'd6, 32'd7);
    tick();
    set_in(1'b0, 32'h0, 32'h0);
    check_all("s0", 1'b1, 32'd6, 32'd6, 32'h0);
    tick();
    check_all("s1", 1'b1, 32'd20, 32'd20, 32'h0);
    tick();
    check_all("s2", 1'b1, 32'd42, 32'd42, 32'h0);
    tick();
    check_all("s.hold", 1'b0, 32'd42, 32'd42, 32'h0);

    // reset one cycle after a valid pair
    set_in(1'b1, 32'd9, 32'd9);
    tick();
    set_in(1'b0, 32'h0, 32'h0);
    tick();
    rst = 1'b0;
    #1;
    check_all("rst.async", 1'b0, 32'h0, 32'h0, 32'h0);
    tick();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_all("rst.drop", 1'b0, 32'h0, 32'h0, 32'h0);
    end
    run_pair("post_rst", 32'd2, 32'd2, 32'd4, 32'd4, 32'h0);

    // random back-to-back pairs on the NAB=0 instance
    for (int i = 0; i < 500; i++) begin
      ra[i] = $urandom;
      rb[i] = $urandom;
    end
    for (int i = 0; i < 502; i++) begin
      if (i < 500) set_in(1'b1, ra[i], rb[i]);
      else         set_in(1'b0, 32'h0, 32'h0);
      tick();
      if (i >= 2) begin
        check("rnd.ov",  32'(bus0.out_valid), 32'h1);
        check("rnd.acc", bus0.c_acc, ra[i-2] * rb[i-2]);
        check("rnd.apx", bus0.c_apx, ra[i-2] * rb[i-2]);
      end
    end
    tick();
    check("rnd.end", 32'(bus0.out_valid), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
